// File: rtl/bus.sv
// Multi-host, multi-device single-cycle bus interconnect.
//
// Purpose:
//   Connects NrHosts request ports to NrDevices response ports. A
//   combinational fixed-priority arbiter picks the lowest-index requesting
//   host. A combinational address decoder then picks the lowest-index device
//   whose (addr & mask) equals its base. Devices respond exactly one cycle
//   after a request. The bus remembers which host and device were involved
//   and steers that device's response back to that host on the next cycle.
//   An address that hits no device is still granted. One cycle later the
//   host sees an error response with rdata = 0.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   host_req_i   [NrHosts] request strobe
//   host_gnt_o   [NrHosts] grant (combinational, same cycle as request)
//   host_addr_i  [NrHosts] request address
//   host_we_i    [NrHosts] write enable
//   host_be_i    [NrHosts] byte enables
//   host_wdata_i [NrHosts] write data
//   host_rvalid_o[NrHosts] response valid, one cycle after grant
//   host_rdata_o [NrHosts] response data (0 for non-addressed hosts)
//   host_err_o   [NrHosts] response error
//   device_req_o   [NrDevices] request to the decoded device only
//   device_addr_o  [NrDevices] selected host address, broadcast
//   device_we_o    [NrDevices] selected host write enable, broadcast
//   device_be_o    [NrDevices] selected host byte enables, broadcast
//   device_wdata_o [NrDevices] selected host write data, broadcast
//   device_rvalid_i[NrDevices] device response valid
//   device_rdata_i [NrDevices] device response data
//   device_err_i   [NrDevices] device response error
//   cfg_device_addr_base[NrDevices] address map base per device
//   cfg_device_addr_mask[NrDevices] address map mask per device

module bus #(
    parameter int unsigned NrDevices    = 1,
    parameter int unsigned NrHosts      = 1,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    host_req_i    [NrHosts],
    output logic                    host_gnt_o    [NrHosts],
    input  logic [AddressWidth-1:0] host_addr_i   [NrHosts],
    input  logic                    host_we_i     [NrHosts],
    input  logic [DataWidth/8-1:0]  host_be_i     [NrHosts],
    input  logic [DataWidth-1:0]    host_wdata_i  [NrHosts],
    output logic                    host_rvalid_o [NrHosts],
    output logic [DataWidth-1:0]    host_rdata_o  [NrHosts],
    output logic                    host_err_o    [NrHosts],

    output logic                    device_req_o    [NrDevices],
    output logic [AddressWidth-1:0] device_addr_o   [NrDevices],
    output logic                    device_we_o     [NrDevices],
    output logic [DataWidth/8-1:0]  device_be_o     [NrDevices],
    output logic [DataWidth-1:0]    device_wdata_o  [NrDevices],
    input  logic                    device_rvalid_i [NrDevices],
    input  logic [DataWidth-1:0]    device_rdata_i  [NrDevices],
    input  logic                    device_err_i    [NrDevices],

    input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

    localparam int unsigned HostIdxW = (NrHosts   > 1) ? $clog2(NrHosts)   : 1;
    localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int unsigned BeW      = DataWidth / 8;

    // Current-cycle selection (combinational)
    logic                    host_sel_valid;
    logic [HostIdxW-1:0]     host_sel_idx;
    logic [AddressWidth-1:0] sel_addr;
    logic                    sel_we;
    logic [BeW-1:0]          sel_be;
    logic [DataWidth-1:0]    sel_wdata;
    logic                    dev_sel_valid;
    logic [DevIdxW-1:0]      dev_sel_idx;

    // Outstanding response bookkeeping
    logic                    pend_q;
    logic [HostIdxW-1:0]     host_q;
    logic [DevIdxW-1:0]      dev_q;
    logic                    dev_valid_q;

    // Response of the remembered device (or the synthesized unmapped error)
    logic                    rsp_rvalid;
    logic                    rsp_err;
    logic [DataWidth-1:0]    rsp_rdata;

    // Fixed-priority arbiter: scan downwards so the lowest index wins.
    always_comb begin
        host_sel_valid = 1'b0;
        host_sel_idx   = '0;
        for (int h = int'(NrHosts) - 1; h >= 0; h--) begin
            if (host_req_i[h]) begin
                host_sel_valid = 1'b1;
                host_sel_idx   = HostIdxW'(h);
            end
        end
    end

    // Mux the selected host's request fields.
    always_comb begin
        sel_addr  = '0;
        sel_we    = 1'b0;
        sel_be    = '0;
        sel_wdata = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (host_sel_idx == HostIdxW'(h)) begin
                sel_addr  = host_addr_i[h];
                sel_we    = host_we_i[h];
                sel_be    = host_be_i[h];
                sel_wdata = host_wdata_i[h];
            end
        end
    end

    // Address decoder: downward scan so the lowest matching device wins.
    always_comb begin
        dev_sel_valid = 1'b0;
        dev_sel_idx   = '0;
        for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
            if ((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
                dev_sel_valid = 1'b1;
                dev_sel_idx   = DevIdxW'(d);
            end
        end
    end

    // Grants: only the selected, requesting host.
    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = host_sel_valid && host_req_i[h] &&
                            (host_sel_idx == HostIdxW'(h));
        end
    end

    // Device side: request to the decoded device, payload broadcast.
    always_comb begin
        for (int unsigned d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = host_sel_valid && dev_sel_valid &&
                                (dev_sel_idx == DevIdxW'(d));
            device_addr_o[d]  = sel_addr;
            device_we_o[d]    = sel_we;
            device_be_o[d]    = sel_be;
            device_wdata_o[d] = sel_wdata;
        end
    end

    // Remember who is owed a response next cycle; reset drops it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q      <= 1'b0;
            host_q      <= '0;
            dev_q       <= '0;
            dev_valid_q <= 1'b0;
        end else begin
            pend_q      <= host_sel_valid;
            host_q      <= host_sel_idx;
            dev_q       <= dev_sel_idx;
            dev_valid_q <= dev_sel_valid;
        end
    end

    // Pick the remembered device's response. An unmapped access answers with an error.
    always_comb begin
        rsp_rvalid = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = '0;
        if (dev_valid_q) begin
            for (int unsigned d = 0; d < NrDevices; d++) begin
                if (dev_q == DevIdxW'(d)) begin
                    rsp_rvalid = device_rvalid_i[d];
                    rsp_err    = device_err_i[d];
                    rsp_rdata  = device_rdata_i[d];
                end
            end
        end else begin
            rsp_rvalid = 1'b1;
            rsp_err    = 1'b1;
            rsp_rdata  = '0;
        end
    end

    // Route the response to the owed host only; everyone else sees zeros.
    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (pend_q && (host_q == HostIdxW'(h))) begin
                host_rvalid_o[h] = rsp_rvalid;
                host_err_o[h]    = rsp_err;
                host_rdata_o[h]  = rsp_rdata;
            end else begin
                host_rvalid_o[h] = 1'b0;
                host_err_o[h]    = 1'b0;
                host_rdata_o[h]  = '0;
            end
        end
    end

endmodule

// File: tb/tb_bus.sv
// Self-checking bench for bus: 3 devices (Ram, SimCtrl, Timer) and 2 hosts.
// Expected values come from an address-range reference model of the map.
module tb_bus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        host_req_i    [2];
    logic        host_gnt_o    [2];
    logic [31:0] host_addr_i   [2];
    logic        host_we_i     [2];
    logic [3:0]  host_be_i     [2];
    logic [31:0] host_wdata_i  [2];
    logic        host_rvalid_o [2];
    logic [31:0] host_rdata_o  [2];
    logic        host_err_o    [2];

    logic        device_req_o    [3];
    logic [31:0] device_addr_o   [3];
    logic        device_we_o     [3];
    logic [3:0]  device_be_o     [3];
    logic [31:0] device_wdata_o  [3];
    logic        device_rvalid_i [3];
    logic [31:0] device_rdata_i  [3];
    logic        device_err_i    [3];
    logic [31:0] cfg_base [3];
    logic [31:0] cfg_mask [3];

    int n_pass = 0;
    int n_total = 0;

    // Reference-model state: the response owed next cycle.
    bit m_pend = 1'b0;
    int m_host = 0;
    int m_dev  = 0;

    // Per-cycle expected and observed values
    logic [1:0]  exp_gnt, obs_gnt;
    logic [2:0]  exp_dreq, obs_dreq;
    logic [63:0] exp_daddr, obs_daddr;
    logic [36:0] exp_dctl, obs_dctl;
    logic [67:0] exp_rsp, obs_rsp;
    int          exp_sel;

    bus #(
        .NrDevices(3), .NrHosts(2), .DataWidth(32), .AddressWidth(32)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
        .host_addr_i(host_addr_i), .host_we_i(host_we_i),
        .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
        .host_err_o(host_err_o),
        .device_req_o(device_req_o), .device_addr_o(device_addr_o),
        .device_we_o(device_we_o), .device_be_o(device_be_o),
        .device_wdata_o(device_wdata_o), .device_rvalid_i(device_rvalid_i),
        .device_rdata_i(device_rdata_i), .device_err_i(device_err_i),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    always #5 clk = ~clk;

    // Address map as plain ranges: Ram 1 MiB at 0x100000, SimCtrl/Timer 1 KiB.
    function automatic int ref_decode(input logic [31:0] a);
        if (a >= 32'h0010_0000 && a < 32'h0020_0000) return 0;
        if (a >= 32'h0002_0000 && a < 32'h0002_0400) return 1;
        if (a >= 32'h0003_0000 && a < 32'h0003_0400) return 2;
        return -1;
    endfunction

    // One bus cycle: drive at negedge, compute expectations, sample, then clock.
    // rd/re are what the device owed a response returns this cycle.
    task automatic apply(input bit r, input logic [1:0] req,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input bit we, input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] rd, input bit re);
        logic [1:0]  rv, er;
        logic [31:0] rdat [2];
        int          dsel;
        @(negedge clk);
        rst = r;
        host_req_i[0] = req[0];  host_req_i[1] = req[1];
        host_addr_i[0] = a0;     host_addr_i[1] = a1;
        host_we_i[0] = we;       host_we_i[1] = ~we;
        host_be_i[0] = be;       host_be_i[1] = ~be;
        host_wdata_i[0] = wd;    host_wdata_i[1] = ~wd;
        for (int d = 0; d < 3; d++) begin
            device_rvalid_i[d] = m_pend && (m_dev == d);
            device_rdata_i[d]  = device_rvalid_i[d] ? rd : $urandom;
            device_err_i[d]    = device_rvalid_i[d] ? re : 1'($urandom_range(1));
        end
        if (r) m_pend = 1'b0;
        rv = '0; er = '0; rdat[0] = '0; rdat[1] = '0;
        if (m_pend) begin
            rv[m_host]   = 1'b1;
            er[m_host]   = (m_dev < 0) ? 1'b1 : re;
            rdat[m_host] = (m_dev < 0) ? 32'h0 : rd;
        end
        exp_rsp = {rv, er, rdat[1], rdat[0]};
        exp_sel = req[0] ? 0 : (req[1] ? 1 : -1);
        dsel    = (exp_sel == 0) ? ref_decode(a0) : ((exp_sel == 1) ? ref_decode(a1) : -1);
        exp_gnt  = (exp_sel < 0) ? 2'b00 : 2'(1 << exp_sel);
        exp_dreq = (dsel < 0) ? 3'b000 : 3'(1 << dsel);
        exp_daddr = (exp_sel == 1) ? {a1, a1} : {a0, a0};
        exp_dctl  = (exp_sel == 1) ? {~we, ~be, ~wd} : {we, be, wd};
        #1;
        obs_gnt   = {host_gnt_o[1], host_gnt_o[0]};
        obs_dreq  = {device_req_o[2], device_req_o[1], device_req_o[0]};
        obs_daddr = {device_addr_o[2], device_addr_o[0]};
        obs_dctl  = {device_we_o[1], device_be_o[1], device_wdata_o[1]};
        obs_rsp   = {host_rvalid_o[1], host_rvalid_o[0], host_err_o[1], host_err_o[0],
                     host_rdata_o[1], host_rdata_o[0]};
        @(posedge clk);
        m_pend = !r && (exp_sel >= 0);
        m_host = (exp_sel < 0) ? 0 : exp_sel;
        m_dev  = dsel;
    endtask

    task automatic idle(input logic [31:0] rd, input bit re);
        apply(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, rd, re);
    endtask

    task automatic test_reset;
        apply(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
        n_total++;
        if (obs_rsp !== 68'h0) $display("FAIL reset_rsp: got %h want %h", obs_rsp, 68'h0);
        else n_pass++;
        n_total++;
        if (obs_gnt !== 2'b00 || obs_dreq !== 3'b000)
            $display("FAIL reset_idle: got gnt %b dreq %b want 00 000", obs_gnt, obs_dreq);
        else n_pass++;
        apply(1'b1, 2'b01, 32'h0010_0010, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        n_total++;
        if (obs_gnt !== exp_gnt || obs_dreq !== exp_dreq)
            $display("FAIL reset_comb_grant: got gnt %b dreq %b want %b %b",
                     obs_gnt, obs_dreq, exp_gnt, exp_dreq);
        else n_pass++;
        apply(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h1234_5678, 1'b0);
        n_total++;
        if (obs_rsp !== 68'h0) $display("FAIL reset_no_rsp: got %h want %h", obs_rsp, 68'h0);
        else n_pass++;
        idle(32'h0, 1'b0);
    endtask

    task automatic test_read_ram;
        apply(1'b0, 2'b01, 32'h0010_0010, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        n_total++;
        if (obs_gnt !== 2'b01 || obs_dreq !== 3'b001 || obs_daddr !== {2{32'h0010_0010}})
            $display("FAIL ram_req: got gnt %b dreq %b addr %h want 01 001 %h",
                     obs_gnt, obs_dreq, obs_daddr, {2{32'h0010_0010}});
        else n_pass++;
        idle(32'hDEAD_BEEF, 1'b0);
        n_total++;
        if (obs_rsp !== exp_rsp || host_rdata_o[0] !== 32'hDEAD_BEEF)
            $display("FAIL ram_rsp: got %h want %h", obs_rsp, exp_rsp);
        else n_pass++;
    endtask

    task automatic test_write_simctrl;
        apply(1'b0, 2'b01, 32'h0002_0000, 32'h0, 1'b1, 4'h1, 32'h41, 32'h0, 1'b0);
        n_total++;
        if (obs_dreq !== 3'b010 || obs_dctl !== {1'b1, 4'h1, 32'h41})
            $display("FAIL simctrl_write: got dreq %b ctl %h want 010 %h",
                     obs_dreq, obs_dctl, {1'b1, 4'h1, 32'h41});
        else n_pass++;
        idle(32'h0, 1'b0);
        n_total++;
        if (obs_rsp !== exp_rsp) $display("FAIL simctrl_rsp: got %h want %h", obs_rsp, exp_rsp);
        else n_pass++;
    endtask

    task automatic test_timer_err;
        apply(1'b0, 2'b01, 32'h0003_0004, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        n_total++;
        if (obs_dreq !== 3'b100) $display("FAIL timer_req: got %b want 100", obs_dreq);
        else n_pass++;
        idle(32'h5555_AAAA, 1'b1);
        n_total++;
        if (obs_rsp !== exp_rsp || host_err_o[0] !== 1'b1)
            $display("FAIL timer_err: got %h want %h", obs_rsp, exp_rsp);
        else n_pass++;
    endtask

    task automatic test_unmapped;
        apply(1'b0, 2'b01, 32'h0004_0000, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        n_total++;
        if (obs_gnt !== 2'b01 || obs_dreq !== 3'b000)
            $display("FAIL unmapped_req: got gnt %b dreq %b want 01 000", obs_gnt, obs_dreq);
        else n_pass++;
        idle(32'hFFFF_FFFF, 1'b0);
        n_total++;
        if (obs_rsp !== {2'b01, 2'b01, 64'h0})
            $display("FAIL unmapped_rsp: got %h want %h", obs_rsp, {2'b01, 2'b01, 64'h0});
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        apply(1'b0, 2'b01, 32'h0010_0000, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        apply(1'b0, 2'b01, 32'h0002_0000, 32'h0, 1'b0, 4'hF, 32'h0, 32'h1111_0000, 1'b0);
        n_total++;
        if (obs_dreq !== 3'b010 || obs_rsp !== exp_rsp || host_rdata_o[0] !== 32'h1111_0000)
            $display("FAIL b2b_first: got dreq %b rsp %h want 010 %h", obs_dreq, obs_rsp, exp_rsp);
        else n_pass++;
        idle(32'h2222_0001, 1'b0);
        n_total++;
        if (obs_rsp !== exp_rsp || host_rdata_o[0] !== 32'h2222_0001)
            $display("FAIL b2b_second: got %h want %h", obs_rsp, exp_rsp);
        else n_pass++;
    endtask

    task automatic test_two_hosts;
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 2'b11, 32'h0002_0010, 32'h0003_0020, 1'b1, 4'h3, 32'hA5A5_0000,
                  32'hC0DE_0000 + 32'(i), 1'b0);
            n_total++;
            if (obs_gnt !== 2'b01 || obs_dreq !== 3'b010 || obs_rsp !== exp_rsp)
                $display("FAIL prio_both: got gnt %b dreq %b rsp %h want 01 010 %h",
                         obs_gnt, obs_dreq, obs_rsp, exp_rsp);
            else n_pass++;
        end
        apply(1'b0, 2'b10, 32'h0002_0010, 32'h0003_0020, 1'b1, 4'h3, 32'hA5A5_0000,
              32'hC0DE_0002, 1'b0);
        n_total++;
        if (obs_gnt !== 2'b10 || obs_dreq !== 3'b100 || obs_dctl !== exp_dctl ||
            obs_daddr !== {2{32'h0003_0020}})
            $display("FAIL prio_host1: got gnt %b dreq %b ctl %h want 10 100 %h",
                     obs_gnt, obs_dreq, obs_dctl, exp_dctl);
        else n_pass++;
        idle(32'h7777_0003, 1'b0);
        n_total++;
        if (obs_rsp !== exp_rsp || host_rvalid_o[1] !== 1'b1 || host_rvalid_o[0] !== 1'b0)
            $display("FAIL host1_rsp: got %h want %h", obs_rsp, exp_rsp);
        else n_pass++;
    endtask

    task automatic test_reset_drop;
        apply(1'b0, 2'b01, 32'h0010_0000, 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
        apply(1'b1, 2'b00, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'hBAD0_BAD0, 1'b0);
        n_total++;
        if (obs_rsp !== 68'h0) $display("FAIL reset_drop: got %h want %h", obs_rsp, 68'h0);
        else n_pass++;
        idle(32'h0, 1'b0);
        n_total++;
        if (obs_rsp !== 68'h0) $display("FAIL reset_drop_after: got %h want %h", obs_rsp, 68'h0);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] a [2];
        for (int i = 0; i < 300; i++) begin
            for (int h = 0; h < 2; h++) begin
                case ($urandom_range(3))
                    0: a[h] = 32'h0010_0000 | ($urandom & 32'h000F_FFFF);
                    1: a[h] = 32'h0002_0000 | ($urandom & 32'h0000_03FF);
                    2: a[h] = 32'h0003_0000 | ($urandom & 32'h0000_03FF);
                    default: a[h] = $urandom;
                endcase
            end
            apply(1'b0, 2'($urandom_range(3)), a[0], a[1], 1'($urandom_range(1)),
                  4'($urandom), $urandom, $urandom, 1'($urandom_range(1)));
            n_total++;
            if (obs_gnt !== exp_gnt || obs_dreq !== exp_dreq)
                $display("FAIL rand_req[%0d]: got gnt %b dreq %b want %b %b",
                         i, obs_gnt, obs_dreq, exp_gnt, exp_dreq);
            else n_pass++;
            if (exp_sel >= 0) begin
                n_total++;
                if (obs_daddr !== exp_daddr || obs_dctl !== exp_dctl)
                    $display("FAIL rand_bcast[%0d]: got %h %h want %h %h",
                             i, obs_daddr, obs_dctl, exp_daddr, exp_dctl);
                else n_pass++;
            end
            n_total++;
            if (obs_rsp !== exp_rsp)
                $display("FAIL rand_rsp[%0d]: got %h want %h", i, obs_rsp, exp_rsp);
            else n_pass++;
        end
    endtask

    initial begin
        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = ~32'h000F_FFFF;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = ~32'h0000_03FF;
        cfg_base[2] = 32'h0003_0000; cfg_mask[2] = ~32'h0000_03FF;
        for (int h = 0; h < 2; h++) begin
            host_req_i[h] = 1'b0; host_addr_i[h] = '0; host_we_i[h] = 1'b0;
            host_be_i[h] = '0; host_wdata_i[h] = '0;
        end
        for (int d = 0; d < 3; d++) begin
            device_rvalid_i[d] = 1'b0; device_rdata_i[d] = '0; device_err_i[d] = 1'b0;
        end
        test_reset;
        test_read_ram;
        test_write_simctrl;
        test_timer_err;
        test_unmapped;
        test_back_to_back;
        test_two_hosts;
        test_reset_drop;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
